// File: rtl/demux_pkg.sv
// Shared constants, FSM encoding and target-selection helper for the 1x4 demux scheduler.
package demux_pkg;

  localparam int unsigned NCH   = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // First enabled channel at or after ptr, wrapping modulo NCH; the descending scan lets the nearest offset win.
  function automatic logic [SEL_W-1:0] pick_target(input logic [SEL_W-1:0] ptr,
                                                    input logic [NCH-1:0]   mask);
    logic [SEL_W-1:0] idx;
    pick_target = ptr;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (mask[idx]) pick_target = idx;
    end
  endfunction

endpackage

// File: rtl/demux_1x4.sv
// One-hot valid decoder: raises bit s when the held word is valid and the decoder is enabled.
module demux_1x4
  import demux_pkg::*;
(
  input  logic             f,
  input  logic             en,
  input  logic [SEL_W-1:0] s,
  output logic [NCH-1:0]   y
);

  assign y = (f && en) ? ({{(NCH-1){1'b0}}, 1'b1} << s) : '0;

endmodule

// File: rtl/demux_sched_1x4.sv
// Round-robin 1-to-4 demux scheduler with a one-entry output register.
// Define DEMUX_SCHED_STATS_EN to add the cnt port and per-channel delivery counters.
module demux_sched_1x4
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NCH-1:0]   cfg_mask,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [NCH-1:0]   out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic [NCH-1:0]   out_ready,
  output logic [SEL_W-1:0] sel
`ifdef DEMUX_SCHED_STATS_EN
  ,
  output logic [NCH*CNT_W-1:0] cnt
`endif
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] target;
  logic             held;
  logic             deliver;
  logic             accept;

  assign held     = (state == HOLD);
  assign deliver  = held && out_ready[sel];
  assign in_ready = en && (cfg_mask != '0) && (!held || out_ready[sel]);
  assign accept   = in_valid && in_ready;
  assign target   = pick_target(ptr, cfg_mask);

  // FSM, rotation pointer and output data register; target is frozen at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      out_data <= '0;
    end else begin
      if (accept) begin
        state    <= HOLD;
        out_data <= in_data;
        sel      <= target;
        ptr      <= target + SEL_W'(1);
      end else if (deliver) begin
        state <= IDLE;
      end
    end
  end

  // The held word stays valid regardless of en, so the decoder enable is tied high.
  demux_1x4 u_demux (
    .f  (held),
    .en (1'b1),
    .s  (sel),
    .y  (out_valid)
  );

`ifdef DEMUX_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt_q [NCH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (deliver && (sel == SEL_W'(k))) cnt_q[k] <= cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < NCH; k++) cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end
`endif

endmodule
